// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I execute stage: one-hot ALU/opcode indices,
// widths, shifter FSM states and a one-bit shift helper.
package rv32i_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_W    = 14;
    localparam int OPCODE_W = 11;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_AND  = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_EQ   = 10;
    localparam int ALU_NEQ  = 11;
    localparam int ALU_GE   = 12;
    localparam int ALU_GEU  = 13;

    localparam int OP_RTYPE  = 0;
    localparam int OP_ITYPE  = 1;
    localparam int OP_LOAD   = 2;
    localparam int OP_STORE  = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE  = 10;

    typedef enum logic [1:0] {
        SH_IDLE  = 2'd0,
        SH_SHIFT = 2'd1,
        SH_DONE  = 2'd2
    } shift_state_e;

    function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] v,
                                                  input logic left,
                                                  input logic arith);
        logic [XLEN-1:0] r;
        if (left) begin
            r = {v[XLEN-2:0], 1'b0};
        end else begin
            r = {arith & v[XLEN-1], v[XLEN-1:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/rv32i_serial_shifter.sv
// One-bit-per-cycle shifter for SLL/SRL/SRA, used only when
// RV32I_ALU_SERIAL_SHIFT_EN is defined.
module rv32i_serial_shifter
    import rv32i_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic            i_hold,
    input  logic            i_left,
    input  logic            i_arith,
    input  logic [XLEN-1:0] i_a,
    input  logic [4:0]      i_shamt,
    output logic            o_busy,
    output logic [XLEN-1:0] o_y
);

    shift_state_e    state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [XLEN-1:0] data_q, data_d;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            state_q <= SH_IDLE;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    // The issue cycle already performs the first shift, so a shift by k
    // costs exactly k bubbles before the result is presented in DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        o_busy  = 1'b0;
        o_y     = data_q;
        case (state_q)
            SH_IDLE: begin
                o_y = i_a;
                if (i_start && (i_shamt != 5'd0)) begin
                    o_busy  = 1'b1;
                    data_d  = shift_one(i_a, i_left, i_arith);
                    count_d = i_shamt - 5'd1;
                    state_d = (i_shamt == 5'd1) ? SH_DONE : SH_SHIFT;
                end
            end
            SH_SHIFT: begin
                o_busy  = 1'b1;
                data_d  = shift_one(data_q, i_left, i_arith);
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d = SH_DONE;
                end
            end
            SH_DONE: begin
                o_y = data_q;
                if (!i_hold) begin
                    state_d = SH_IDLE;
                end
            end
            default: begin
                state_d = SH_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute stage: ALU, branch/jump redirect, writeback select and the
// stage-3/4 pipeline register. RV32I_ALU_SERIAL_SHIFT_EN selects a serial shifter.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ALU_W-1:0]    i_alu,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [2:0]          i_funct3,
    input  logic [XLEN-1:0]     i_rs1,
    input  logic [XLEN-1:0]     i_rs2,
    input  logic [XLEN-1:0]     i_imm,
    input  logic [XLEN-1:0]     i_pc,
    input  logic [4:0]          i_rd_addr,
    input  logic                i_force_stall,
    input  logic                i_ce,
    input  logic                i_stall,
    input  logic                i_flush,
    output logic                o_stall,
    output logic                o_flush,
    output logic                o_change_pc,
    output logic [XLEN-1:0]     o_next_pc,
    output logic [4:0]          o_rd_addr,
    output logic                o_wr_rd,
    output logic                o_rd_valid,
    output logic [XLEN-1:0]     o_rd,
    output logic [XLEN-1:0]     o_y,
    output logic [XLEN-1:0]     o_rs2,
    output logic [2:0]          o_funct3,
    output logic [OPCODE_W-1:0] o_opcode,
    output logic                o_ce
);

    logic [XLEN-1:0]        op_a, op_b;
    logic signed [XLEN-1:0] a_s, b_s;
    logic [XLEN-1:0]        y_d, rd_d, next_pc_d, pc_imm, pc_4, jalr_tgt;
    logic                   wr_rd_d, rd_valid_d, taken_d, is_shift;
    logic                   shift_busy, stall_bit;
    logic [XLEN-1:0]        shift_y;

    logic                   ce_q, change_pc_q, flush_q, wr_rd_q, rd_valid_q;
    logic [4:0]             rd_addr_q;
    logic [XLEN-1:0]        rd_q, y_q, rs2_q, next_pc_q;
    logic [2:0]             funct3_q;
    logic [OPCODE_W-1:0]    opcode_q;

    assign op_a = (i_opcode[OP_AUIPC] || i_opcode[OP_JAL]) ? i_pc : i_rs1;
    assign op_b = (i_opcode[OP_RTYPE] || i_opcode[OP_BRANCH]) ? i_rs2 : i_imm;
    assign a_s  = op_a;
    assign b_s  = op_b;

    assign is_shift = i_alu[ALU_SLL] | i_alu[ALU_SRL] | i_alu[ALU_SRA];

`ifdef RV32I_ALU_SERIAL_SHIFT_EN
    rv32i_serial_shifter u_shifter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_start (i_ce & is_shift),
        .i_hold  (i_stall | i_force_stall),
        .i_left  (i_alu[ALU_SLL]),
        .i_arith (i_alu[ALU_SRA]),
        .i_a     (op_a),
        .i_shamt (op_b[4:0]),
        .o_busy  (shift_busy),
        .o_y     (shift_y)
    );
`else
    assign shift_busy = 1'b0;
    always_comb begin
        shift_y = '0;
        if (i_alu[ALU_SLL]) shift_y = op_a << op_b[4:0];
        if (i_alu[ALU_SRL]) shift_y = op_a >> op_b[4:0];
        if (i_alu[ALU_SRA]) shift_y = a_s >>> op_b[4:0];
    end
`endif

    always_comb begin
        y_d = '0;
        if (i_alu[ALU_ADD])  y_d = op_a + op_b;
        if (i_alu[ALU_SUB])  y_d = op_a - op_b;
        if (i_alu[ALU_SLT])  y_d = {31'd0, a_s < b_s};
        if (i_alu[ALU_SLTU]) y_d = {31'd0, op_a < op_b};
        if (i_alu[ALU_XOR])  y_d = op_a ^ op_b;
        if (i_alu[ALU_OR])   y_d = op_a | op_b;
        if (i_alu[ALU_AND])  y_d = op_a & op_b;
        if (is_shift)        y_d = shift_y;
        if (i_alu[ALU_EQ])   y_d = {31'd0, op_a == op_b};
        if (i_alu[ALU_NEQ])  y_d = {31'd0, op_a != op_b};
        if (i_alu[ALU_GE])   y_d = {31'd0, a_s >= b_s};
        if (i_alu[ALU_GEU])  y_d = {31'd0, op_a >= op_b};
    end

    assign pc_imm   = i_pc + i_imm;
    assign pc_4     = i_pc + 32'd4;
    assign jalr_tgt = (i_rs1 + i_imm) & ~32'd1;

    always_comb begin
        rd_d = y_d;
        if (i_opcode[OP_LUI])                        rd_d = i_imm;
        if (i_opcode[OP_AUIPC])                      rd_d = pc_imm;
        if (i_opcode[OP_JAL] || i_opcode[OP_JALR])   rd_d = pc_4;
    end

    assign wr_rd_d    = ~(i_opcode[OP_BRANCH] | i_opcode[OP_STORE] | i_opcode[OP_FENCE])
                        & (i_rd_addr != 5'd0);
    assign rd_valid_d = ~(i_opcode[OP_LOAD] | i_opcode[OP_SYSTEM]);
    assign taken_d    = i_opcode[OP_JAL] | i_opcode[OP_JALR] | (i_opcode[OP_BRANCH] & y_d[0]);
    assign next_pc_d  = i_opcode[OP_JALR] ? jalr_tgt : pc_imm;

    assign stall_bit = i_stall | i_force_stall | shift_busy;
    assign o_stall   = stall_bit | i_stall;

    // Stage 3 -> stage 4 boundary. Redirect is cleared on every
    // non-advancing cycle so fetch sees a single-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ce_q        <= 1'b0;
            change_pc_q <= 1'b0;
            flush_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_q        <= '0;
            y_q         <= '0;
            rs2_q       <= '0;
            next_pc_q   <= '0;
            funct3_q    <= '0;
            opcode_q    <= '0;
        end else if (i_flush) begin
            ce_q        <= 1'b0;
            change_pc_q <= 1'b0;
            flush_q     <= 1'b0;
        end else if (stall_bit) begin
            change_pc_q <= 1'b0;
            flush_q     <= 1'b0;
            if (!i_stall) begin
                ce_q <= 1'b0;
            end
        end else if (i_ce) begin
            ce_q        <= 1'b1;
            change_pc_q <= taken_d;
            flush_q     <= taken_d;
            wr_rd_q     <= wr_rd_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= i_rd_addr;
            rd_q        <= rd_d;
            y_q         <= y_d;
            rs2_q       <= i_rs2;
            next_pc_q   <= next_pc_d;
            funct3_q    <= i_funct3;
            opcode_q    <= i_opcode;
        end else begin
            ce_q        <= 1'b0;
            change_pc_q <= 1'b0;
            flush_q     <= 1'b0;
        end
    end

    assign o_ce        = ce_q;
    assign o_change_pc = change_pc_q;
    assign o_flush     = flush_q;
    assign o_wr_rd     = wr_rd_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_rd        = rd_q;
    assign o_y         = y_q;
    assign o_rs2       = rs2_q;
    assign o_next_pc   = next_pc_q;
    assign o_funct3    = funct3_q;
    assign o_opcode    = opcode_q;

endmodule
